// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus sequencer and the write/read controllers
// that sit beside it: state encoding and timing defaults.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int GAP_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF    = 127;

endpackage

// File: rtl/rtc_bus_sequencer.sv
// Sequences single writes and burst reads on the RTC bus.
// The timing generator beside it provides the phase flags and the end-of-transfer pulse.
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    input  logic [2:0] req_len,
    input  logic       DIR1,
    input  logic       DAT1,
    input  logic       DAT_LECT,
    input  logic       cambio_est2,
    input  logic [7:0] dato_in,
    output logic       En_Esc,
    output logic       En_Lect,
    output logic [7:0] dato_out,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int WW = $clog2(TIMEOUT + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    seq_state_t    state;
    logic          op_wr;
    logic          loaded;
    logic          aborting;
    logic [7:0]    addr;
    logic [7:0]    wdata;
    logic [2:0]    remaining;
    logic [GW-1:0] gap_cnt;
    logic [WW-1:0] wd_cnt;

    // The address phase needs no action here: dato_out already holds the address.
    logic unused_dir1;
    assign unused_dir1 = DIR1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_wr     <= 1'b0;
            loaded    <= 1'b0;
            aborting  <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            wd_cnt    <= '0;
            En_Esc    <= 1'b0;
            En_Lect   <= 1'b0;
            dato_out  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_wr || req_rd) begin
                        op_wr     <= req_wr;
                        addr      <= req_addr;
                        wdata     <= req_data;
                        remaining <= req_wr ? 3'd0 : req_len;
                        dato_out  <= req_addr;
                        En_Esc    <= req_wr;
                        En_Lect   <= !req_wr;
                        busy      <= 1'b1;
                        wd_cnt    <= '0;
                        loaded    <= 1'b0;
                        aborting  <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (op_wr && DAT1 && !loaded) begin
                        dato_out <= wdata;
                        loaded   <= 1'b1;
                    end
                    if (!op_wr && DAT_LECT)
                        rd_data <= dato_in;
                    if (cambio_est2) begin
                        En_Esc   <= 1'b0;
                        En_Lect  <= 1'b0;
                        rd_valid <= !op_wr;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else if (wd_cnt == WD_LAST) begin
                        // Watchdog expiry drops the rest of the burst; the gap still runs
                        // so the timing generator sees its enable released cleanly.
                        En_Esc   <= 1'b0;
                        En_Lect  <= 1'b0;
                        error    <= 1'b1;
                        aborting <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (aborting) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (remaining != 3'd0) begin
                            remaining <= remaining - 3'd1;
                            addr      <= addr + 8'd1;
                            dato_out  <= addr + 8'd1;
                            En_Esc    <= op_wr;
                            En_Lect   <= !op_wr;
                            wd_cnt    <= '0;
                            loaded    <= 1'b0;
                            state     <= ST_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench: a behavioural timing generator drives the phase flags, stimulus
// queues the expected bus events and a negedge monitor checks what the sequencer does.
module tb_rtc_bus_sequencer;

    localparam logic [2:0] K_ADDR_W = 3'd0, K_ADDR_R = 3'd1, K_RD = 3'd2, K_DATA = 3'd3,
                           K_DONE = 3'd4, K_ERR = 3'd5, K_GAP = 3'd6, K_BFALL = 3'd7;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_wr = 1'b0, req_rd = 1'b0;
    logic [7:0] req_addr = '0, req_data = '0;
    logic [2:0] req_len = '0;
    logic       DIR1 = 1'b0, DAT1 = 1'b0, DAT_LECT = 1'b0, cambio_est2 = 1'b0;
    logic [7:0] dato_in = '0;
    logic       En_Esc, En_Lect, rd_valid, busy, done, error;
    logic [7:0] dato_out, rd_data;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rd_vals[8];
    int         rd_idx = 0;
    int         tg_cnt = 0;
    logic       cambio_en = 1'b1;

    rtc_bus_sequencer dut (
        .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
        .req_addr(req_addr), .req_data(req_data), .req_len(req_len),
        .DIR1(DIR1), .DAT1(DAT1), .DAT_LECT(DAT_LECT), .cambio_est2(cambio_est2),
        .dato_in(dato_in), .En_Esc(En_Esc), .En_Lect(En_Lect), .dato_out(dato_out),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Timing generator: DIR1 x2, DAT1 x2, DAT_LECT, then the end-of-transfer pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (reset || !(En_Esc || En_Lect)) tg_cnt = 0;
            else tg_cnt++;
            DIR1        = (tg_cnt == 1) || (tg_cnt == 2);
            DAT1        = (tg_cnt == 3) || (tg_cnt == 4);
            DAT_LECT    = (tg_cnt == 5);
            dato_in     = (tg_cnt == 5) ? rd_vals[rd_idx % 8] : 8'hEE;
            cambio_est2 = cambio_en && (tg_cnt == 6);
            if (cambio_est2) rd_idx++;
        end
    end

    task automatic push(input logic [2:0] k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic report(input logic [2:0] k, input logic [7:0] v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d val %02h, expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                n_bad++;
                $display("FAIL event: got kind %0d val %02h, expected kind %0d val %02h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and checks them against the queue.
    initial begin
        logic prev_en = 1'b0, prev_esc = 1'b0, prev_busy = 1'b0, had_fall = 1'b0;
        logic [7:0] prev_dato = '0;
        int low_cnt = 0, since_rise = 0, since_strobe = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = 1'b0; prev_esc = 1'b0; prev_busy = 1'b0; had_fall = 1'b0;
                prev_dato = '0; low_cnt = 0; since_rise = 0; since_strobe = 0;
            end else begin
                since_rise++;
                since_strobe++;
                if ((En_Esc || En_Lect) && !prev_en) begin
                    if (had_fall) report(K_GAP, 8'(low_cnt));
                    report(En_Esc ? K_ADDR_W : K_ADDR_R, dato_out);
                    since_rise = 0;
                end
                if (!(En_Esc || En_Lect) && prev_en) begin
                    low_cnt = 1;
                    had_fall = 1'b1;
                end else if (!(En_Esc || En_Lect)) begin
                    low_cnt++;
                end
                if (En_Esc && prev_esc && dato_out != prev_dato) report(K_DATA, dato_out);
                if (rd_valid) report(K_RD, rd_data);
                if (error) begin
                    report(K_ERR, 8'(since_rise > 255 ? 255 : since_rise));
                    since_strobe = 0;
                end
                if (done) begin
                    report(K_DONE, 8'h00);
                    since_strobe = 0;
                end
                if (prev_busy && !busy) begin
                    report(K_BFALL, 8'(since_strobe > 255 ? 255 : since_strobe));
                    had_fall = 1'b0;
                end
                prev_en   = En_Esc || En_Lect;
                prev_esc  = En_Esc;
                prev_dato = dato_out;
                prev_busy = busy;
            end
        end
    end

    task automatic check_zero(input string name);
        logic [21:0] act;
        act = {En_Esc, En_Lect, rd_valid, done, error, busy, dato_out, rd_data};
        n_cmp++;
        if (act !== 22'd0) begin
            n_bad++;
            $display("FAIL %s: outputs %06h, expected 000000", name, act);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 1000; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (k == 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: busy still 1 after 1000 cycles, expected 0", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [7:0] a,
                         input logic [7:0] d, input logic [2:0] len, input logic poke);
        @(negedge clk);
        req_wr = wr; req_rd = rd; req_addr = a; req_data = d; req_len = len;
        @(negedge clk);
        req_wr = 1'b0; req_rd = 1'b0;
        if (poke) begin
            // Requests while busy must leave no trace.
            repeat (3) @(negedge clk);
            req_wr = 1'b1; req_rd = 1'b1; req_addr = 8'hC3; req_len = 3'd7;
            @(negedge clk);
            req_wr = 1'b0; req_rd = 1'b0;
        end
    endtask

    initial begin
        int k;
        #2;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single write
        push(K_ADDR_W, 8'h21); push(K_DATA, 8'h45); push(K_DONE, 8'h00); push(K_BFALL, 8'd1);
        issue(1'b1, 1'b0, 8'h21, 8'h45, 3'd0, 1'b0);
        wait_idle("write");

        // Three-transfer read burst with a request poked in while busy
        rd_idx = 0;
        rd_vals[0] = 8'h11; rd_vals[1] = 8'h22; rd_vals[2] = 8'h33;
        push(K_ADDR_R, 8'h00); push(K_RD, 8'h11); push(K_GAP, 8'd2);
        push(K_ADDR_R, 8'h01); push(K_RD, 8'h22); push(K_GAP, 8'd2);
        push(K_ADDR_R, 8'h02); push(K_RD, 8'h33); push(K_DONE, 8'h00); push(K_BFALL, 8'd1);
        issue(1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b1);
        wait_idle("read_burst");

        // Both requests together: one write only
        push(K_ADDR_W, 8'h40); push(K_DATA, 8'h5A); push(K_DONE, 8'h00); push(K_BFALL, 8'd1);
        issue(1'b1, 1'b1, 8'h40, 8'h5A, 3'd5, 1'b0);
        wait_idle("wr_rd_both");

        // Address wrap 0xFF -> 0x00
        rd_idx = 0;
        rd_vals[0] = 8'h77; rd_vals[1] = 8'h88;
        push(K_ADDR_R, 8'hFF); push(K_RD, 8'h77); push(K_GAP, 8'd2);
        push(K_ADDR_R, 8'h00); push(K_RD, 8'h88); push(K_DONE, 8'h00); push(K_BFALL, 8'd1);
        issue(1'b0, 1'b1, 8'hFF, 8'h00, 3'd1, 1'b0);
        wait_idle("addr_wrap");

        // Watchdog: no end-of-transfer pulse
        cambio_en = 1'b0;
        rd_idx = 0;
        push(K_ADDR_R, 8'h08); push(K_ERR, 8'd127); push(K_BFALL, 8'd2);
        issue(1'b0, 1'b1, 8'h08, 8'h00, 3'd3, 1'b0);
        wait_idle("timeout");
        cambio_en = 1'b1;

        // Reset during the second transfer of a burst
        rd_idx = 0;
        rd_vals[0] = 8'hA1; rd_vals[1] = 8'hA2;
        push(K_ADDR_R, 8'h10); push(K_RD, 8'hA1); push(K_GAP, 8'd2); push(K_ADDR_R, 8'h11);
        issue(1'b0, 1'b1, 8'h10, 8'h00, 3'd3, 1'b0);
        for (k = 0; k < 500; k++) begin
            if (rd_idx == 1 && tg_cnt == 3) break;
            @(negedge clk);
        end
        if (k == 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL second_xfer_wait: not reached in 500 cycles, expected reached");
        end
        #2 reset = 1'b1;
        #1 check_zero("reset_mid_burst");
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_mid_burst_held");
        #2 reset = 1'b0;
        rd_idx = 0;
        repeat (10) @(negedge clk);
        check_zero("idle_after_reset");

        push(K_ADDR_W, 8'h30); push(K_DATA, 8'h99); push(K_DONE, 8'h00); push(K_BFALL, 8'd1);
        issue(1'b1, 1'b0, 8'h30, 8'h99, 3'd0, 1'b0);
        wait_idle("write_after_reset");

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: %0d still queued, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 2, idle cycles with both enables low between consecutive transfers.
REQ-002 Parameter TIMEOUT, default 127, max cycles in RUN waiting for cambio_est2 before abort.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req_wr  in  1  write request, sampled only in IDLE.
REQ-007 req_rd  in  1  read request, sampled only in IDLE.
REQ-008 req_addr  in  8  RTC register address.
REQ-009 req_data  in  8  write data.
REQ-010 req_len  in  3  read burst length minus one (0 = 1 transfer, 7 = 8 transfers).
REQ-011 DIR1  in  1  address-phase flag from timing generator.
REQ-012 DAT1  in  1  data-phase flag from timing generator.
REQ-013 DAT_LECT  in  1  read-sample window from timing generator.
REQ-014 cambio_est2  in  1  single-cycle end-of-transfer pulse from timing generator.
REQ-015 dato_in  in  8  RTC bus value during read.
REQ-016 En_Esc  out  1  write enable to timing generator.
REQ-017 En_Lect  out  1  read enable to timing generator.
REQ-018 dato_out  out  8  value presented to bus tri-state driver.
REQ-019 rd_data  out  8  captured read byte.
REQ-020 rd_valid  out  1  one-cycle strobe, rd_data valid.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 done  out  1  one-cycle strobe, request complete.
REQ-023 error  out  1  one-cycle strobe, transfer timed out.

Function
REQ-024 FSM states IDLE, RUN, GAP, DONE; all outputs registered.
REQ-025 IDLE: req_wr or req_rd high -> capture addr, data, len, op; next cycle RUN; req_wr wins if both high (len forced 0).
REQ-026 Requests while busy=1 are ignored, no queuing.
REQ-027 RUN: En_Esc=1 for write or En_Lect=1 for read, the other 0; watchdog counter cleared on RUN entry.
REQ-028 dato_out = current address from acceptance/RUN entry; write only: first cycle DAT1=1 loads captured data, held until RUN exits.
REQ-029 Read: every cycle DAT_LECT=1, rd_data <= dato_in (last sample wins); the cycle after cambio_est2, rd_valid=1 for one cycle.
REQ-030 RUN + cambio_est2=1 -> GAP; enables low for exactly GAP_CYCLES cycles so the timing counter restarts.
REQ-031 GAP end: remaining transfers >0 -> address+1 (8-bit wrap, 0xFF->0x00), dato_out updated, RUN; else DONE.
REQ-032 DONE: done=1 for one cycle, then IDLE; new request accepted in IDLE the following cycle earliest.
REQ-033 RUN for TIMEOUT cycles without cambio_est2 -> error=1 one cycle, remaining burst discarded, GAP then IDLE; no done, no rd_valid.
REQ-034 DIR1/DAT1/DAT_LECT outside RUN are ignored.

Reset
REQ-035 On reset, immediately: state IDLE; En_Esc, En_Lect, rd_valid, done, error, busy = 0; dato_out, rd_data = 0x00; counters 0.
REQ-036 Reset mid-RUN or mid-burst aborts with no done/error strobe; operation resumes only on a new request.

Structure
REQ-037 Shared package rtc_pkg holds state encoding, GAP_CYCLES and TIMEOUT defaults, shared with the write/read controllers.
REQ-038 Single flat module; the timing generator is instantiated beside it by the parent, not inside.

Verification
REQ-039 Write addr 0x21 data 0x45 with timing generator attached -> En_Esc one window, dato_out 0x21 then 0x45 at DAT1, done once, rd_valid never.
REQ-040 Read addr 0x00 len 2, dato_in 0x11/0x22/0x33 per transfer -> three rd_valid with those values, addresses 0x00,0x01,0x02, 2 low-enable cycles between, done once.
REQ-041 req_wr and req_rd high together, len 5 -> single write only, En_Lect never asserted.
REQ-042 Read addr 0xFF len 1 -> second transfer uses address 0x00.
REQ-043 Read with cambio_est2 held low -> error pulse 127 cycles after RUN entry, busy drops after GAP, no done.
REQ-044 Assert reset during second transfer of burst -> all outputs zero same cycle, busy 0, no strobes; next request completes normally.
